click_classifier: RTL
=====================

# click_classifier

Consumes the single-cycle `btn_pulse` produced by the debounce stage and groups pulses into click bursts: single, double or triple press within a time window. Each finished burst becomes one event (click count) presented to downstream game-control logic over a valid/ready handshake. Sits directly after `debounce` on each player button; one instance per button.

## Interface

- `WINDOW`, default 5000: maximum gap in `clk` cycles between consecutive pulses of one burst; legal range ≥ 2.
- `MAX_CLICKS`, default 3: burst size that closes a burst immediately; legal range 1..3.

- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `btn_pulse`  in  1  one-cycle press pulse from the debounce stage.
- `evt_ready`  in  1  downstream accepts the event this cycle.
- `evt_valid`  out  1  event held and valid.
- `evt_count`  out  2  clicks in the burst, 1..MAX_CLICKS; meaningful only while `evt_valid`=1.
- `overflow`  out  1  sticky; an event was dropped because the output slot was occupied.

## Operation

- Internal registers:
  - Burst counter `cnt` (2 bits).
  - Gap timer `timer`, width `$clog2(WINDOW)`.
  - One-deep output slot (`evt_valid`/`evt_count`).
- FSM states: IDLE, COUNTING.
- IDLE:
  - `btn_pulse`=1 → `cnt`=1, `timer`=0.
  - If MAX_CLICKS=1: emit 1 and stay IDLE.
  - Otherwise go to COUNTING.
- COUNTING, evaluated in priority order each cycle:
  1. `btn_pulse`=1:
     - `cnt`+1, `timer`=0.
     - If the new `cnt`=MAX_CLICKS: emit it and go to IDLE.
  2. No pulse and `timer`=WINDOW-1: emit `cnt`, go to IDLE.
  3. Otherwise: `timer`+1.
- A pulse arriving in the same cycle as the timeout is counted; pulse has priority.
- Emit rule:
  - Slot free (`evt_valid`=0) or being drained this cycle (`evt_valid`&&`evt_ready`): load `evt_count`, set `evt_valid`=1 next cycle.
  - Otherwise: drop the event, keep the old event unchanged, set `overflow`=1.
- Handshake:
  - Transfer occurs on a cycle with `evt_valid`&&`evt_ready`.
  - `evt_valid` clears the following cycle unless a simultaneous emit reloads it.
  - `evt_count` stays stable while `evt_valid`=1 and `evt_ready`=0.
  - `evt_ready` while `evt_valid`=0 has no effect.
- `overflow` clears only on `rst`.
- `cnt` never wraps; it is bounded by MAX_CLICKS.

## Timing

- Reset values:
  - State IDLE, `cnt`=0, `timer`=0.
  - `evt_valid`=0, `evt_count`=0, `overflow`=0.
- `rst` asserted mid-burst discards the burst.
- `rst` discards a pending un-accepted event.
- `rst` has priority over `btn_pulse` in the same cycle.
- Timeout latency: with the last counted pulse sampled at edge T, `evt_valid` is high after edge T+WINDOW if no further pulse arrives in edges T+1..T+WINDOW.
- Max-click latency: `evt_valid` is high after the edge that samples the MAX_CLICKS-th pulse (1 cycle).
- A pulse on the cycle right after a max-click close starts a new burst in IDLE.
- Every registered output updates only on a `clk` rising edge; no combinational path from `btn_pulse` or `evt_ready` to any output.

## Test plan

Bench uses WINDOW=20 and MAX_CLICKS=3 unless stated.

1. Single click:
   - Stimulus: one pulse at edge 10, `evt_ready`=1.
   - Required: `evt_valid`=1 with `evt_count`=1 only after edge 30, for exactly one cycle.
2. Double click at window edge:
   - Stimulus: pulses at edges 10 and 29 (gap 19).
   - Required: `evt_count`=2, valid after edge 49.
   - Repeat with pulses at edges 10 and 31: required two events with `evt_count`=1 each.
3. Triple click, immediate close:
   - Stimulus: pulses at edges 10, 15, 20.
   - Required: `evt_count`=3, valid after edge 20.
   - A fourth pulse at edge 21 must start a new burst that reports 1 after edge 41.
4. Backpressure and overflow:
   - Stimulus: `evt_ready`=0, two single-click bursts.
   - Required: first event (count 1) held stable; second dropped; `overflow`=1 and stays 1 after `evt_ready` rises.
   - Only one transfer occurs.
5. Drain/emit collision:
   - Stimulus: `evt_ready`=1 on the exact cycle a new emit fires.
   - Required: old event transferred, new one loaded, `evt_valid` stays high with the new count, `overflow`=0.
6. Reset mid-burst:
   - Stimulus: `rst` for 1 cycle after the second pulse of a burst.
   - Required: no event emitted; all outputs 0; the next pulse yields `evt_count`=1.
   - Also run with WINDOW=5000 and MAX_CLICKS=1: each pulse must emit 1 after one cycle.

Source files
------------

// File: rtl/click_classifier.sv
// Groups debounced button pulses into click bursts (1..MAX_CLICKS) and presents
// each finished burst as one event in a one-deep valid/ready output slot.
module click_classifier #(
  parameter int WINDOW     = 5000,
  parameter int MAX_CLICKS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_pulse,
  input  logic       evt_ready,
  output logic       evt_valid,
  output logic [1:0] evt_count,
  output logic       overflow
);

  // Handshake: an event transfers on any cycle with evt_valid && evt_ready;
  // evt_count is held stable while evt_valid is high and evt_ready is low,
  // and evt_ready has no effect while evt_valid is low.

  localparam int TW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(WINDOW - 1);
  localparam logic [1:0]    CNT_MAX    = 2'(MAX_CLICKS);

  typedef enum logic {
    IDLE,
    COUNTING
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [1:0]      cnt;
  logic [1:0]      cnt_next;
  logic [TW-1:0]   timer;
  logic [TW-1:0]   timer_next;
  logic            emit;
  logic [1:0]      emit_count;
  logic            slot_open;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    timer_next = timer;
    emit       = 1'b0;
    emit_count = cnt;
    case (state)
      IDLE: begin
        if (btn_pulse) begin
          cnt_next   = 2'd1;
          timer_next = '0;
          if (MAX_CLICKS == 1) begin
            emit       = 1'b1;
            emit_count = 2'd1;
          end else begin
            state_next = COUNTING;
          end
        end
      end
      COUNTING: begin
        // A pulse coinciding with the timeout is still counted.
        if (btn_pulse) begin
          cnt_next   = cnt + 2'd1;
          timer_next = '0;
          if (cnt + 2'd1 == CNT_MAX) begin
            emit       = 1'b1;
            emit_count = cnt + 2'd1;
            state_next = IDLE;
          end
        end else if (timer == TIMER_LAST) begin
          emit       = 1'b1;
          emit_count = cnt;
          state_next = IDLE;
        end else begin
          timer_next = timer + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign slot_open = !evt_valid || evt_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      timer     <= '0;
      evt_valid <= 1'b0;
      evt_count <= 2'd0;
      overflow  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      timer <= timer_next;
      // An emit into a full, non-draining slot is dropped and flagged.
      if (emit) begin
        if (slot_open) begin
          evt_valid <= 1'b1;
          evt_count <= emit_count;
        end else begin
          overflow <= 1'b1;
        end
      end else if (evt_valid && evt_ready) begin
        evt_valid <= 1'b0;
      end
    end
  end

endmodule
